// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving a Block_RAM: port-A byte-lane writes, port-B zero-wait reads,
// with a registered forwarding path covering write-then-read of the same word.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;
    logic                  fwd_hit_q, fwd_hit_d;

    logic                  accept;
    logic                  legal;
    logic                  rd_accept;
    logic [3:0]            req_mask;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic                  unused_bits;

    // Upper address bits are dropped on purpose: the RAM aliases across the bus window.
    assign haddr_word  = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
    assign accept      = HSEL & HREADY & HTRANS[1];
    assign rd_accept   = accept & legal & ~HWRITE;
    assign addrb       = haddr_word;

    always_comb begin
        legal    = 1'b0;
        req_mask = 4'b0000;
        case (HSIZE)
            3'd0: begin
                legal    = 1'b1;
                req_mask = 4'b0001 << HADDR[1:0];
            end
            3'd1: begin
                legal    = ~HADDR[0];
                req_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal    = (HADDR[1:0] == 2'b00);
                req_mask = 4'b1111;
            end
            default: begin
                legal    = 1'b0;
                req_mask = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d = S_IDLE;
        waddr_d = waddr_q;
        wmask_d = wmask_q;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (accept) begin
            if (!legal) begin
                state_d = S_ERR1;
            end else if (HWRITE) begin
                state_d = S_WRITE;
                waddr_d = haddr_word;
                wmask_d = req_mask;
            end else begin
                state_d = S_READ;
            end
        end
    end

    // A write still in its data phase when reset arrives is suppressed, leaving the word intact.
    always_comb begin
        wea   = 4'b0000;
        addra = '0;
        dina  = 32'h0;
        if (state_q == S_WRITE && !rst) begin
            wea   = wmask_q;
            addra = waddr_q;
            dina  = HWDATA;
        end
    end

    assign HREADYOUT = (state_q != S_ERR1);
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

    // The RAM returns pre-write data for a read issued during a write; remember the write to patch it.
    always_comb begin
        fwd_data_d = fwd_data_q;
        fwd_mask_d = fwd_mask_q;
        fwd_hit_d  = 1'b0;
        if (|wea) begin
            fwd_data_d = dina;
            fwd_mask_d = wea;
            fwd_hit_d  = rd_accept && (haddr_word == addra);
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (state_q == S_READ) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = (fwd_hit_q && fwd_mask_q[i]) ? fwd_data_q[8*i +: 8]
                                                                 : doutb[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q   <= S_IDLE;
            waddr_q   <= '0;
            wmask_q   <= 4'b0000;
            fwd_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            wmask_q   <= wmask_d;
            fwd_hit_q <= fwd_hit_d;
        end
    end

    always_ff @(posedge clka) begin
        fwd_data_q <= fwd_data_d;
        fwd_mask_q <= fwd_mask_d;
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: attached RAM, transfer-level memory model with a per-cycle compare,
// directed literal scenarios and a randomized AHB transfer stream.
module tb_ahb_bram_ctrl;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          clka   = 1'b0;
    logic          rst    = 1'b1;
    logic          HSEL   = 1'b0;
    logic [31:0]   HADDR  = 32'h0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE  = 3'd0;
    logic          HREADY;
    logic [31:0]   HWDATA = 32'h0;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [AW-1:0] addra;
    logic [31:0]   dina;
    logic [3:0]    wea;
    logic [AW-1:0] addrb;
    logic [31:0]   doutb;
    logic          stall  = 1'b0;

    int checks   = 0;
    int failures = 0;

    bit [31:0] ram     [DEPTH];
    bit [31:0] ref_mem [DEPTH];

    typedef enum int {K_NONE, K_WR, K_RD, K_E1, K_E2} kind_t;
    kind_t    dp_kind  = K_NONE;
    int       dp_word  = 0;
    bit [3:0] dp_mask  = 4'b0;
    bit       model_ok = 1'b0;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clka      (clka),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .addrb     (addrb),
        .doutb     (doutb)
    );

    always #5 clka = ~clka;

    // Single slave on the bus; stall stands in for another slave holding HREADY low.
    assign HREADY = HREADYOUT & ~stall;

    // Block_RAM: byte-lane write on port A, registered read-old-data on port B.
    always @(posedge clka) begin
        logic [31:0] w;
        w = ram[addra];
        for (int i = 0; i < 4; i++) begin
            if (wea[i]) w[8*i +: 8] = dina[8*i +: 8];
        end
        if (|wea) ram[addra] <= w;
        doutb <= ram[addrb];
    end

    // Transfer-level model: what is in the data phase, and what memory must contain.
    always @(posedge clka) begin
        int  nb;
        bit  hr;
        bit  lgl;
        if (rst) begin
            dp_kind  = K_NONE;
            model_ok = 1'b1;
        end else begin
            if (dp_kind == K_WR) begin
                for (int i = 0; i < 4; i++) begin
                    if (dp_mask[i]) ref_mem[dp_word][8*i +: 8] = HWDATA[8*i +: 8];
                end
            end
            hr = (dp_kind != K_E1) && !stall;
            if (dp_kind == K_E1) begin
                dp_kind = K_E2;
            end else if (HSEL && hr && HTRANS[1]) begin
                nb  = 1 << HSIZE;
                lgl = (HSIZE <= 3'd2) && ((int'(HADDR[1:0]) % nb) == 0);
                dp_word = int'((HADDR >> 2) & (DEPTH - 1));
                if (!lgl) begin
                    dp_kind = K_E1;
                end else if (HWRITE) begin
                    dp_kind = K_WR;
                    dp_mask = 4'(((1 << nb) - 1) << HADDR[1:0]);
                end else begin
                    dp_kind = K_RD;
                end
            end else begin
                dp_kind = K_NONE;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clka) begin
        if (model_ok && !rst) begin
            chk("m_hreadyout", HREADYOUT, dp_kind != K_E1);
            chk("m_hresp", HRESP, (dp_kind == K_E1) || (dp_kind == K_E2));
            chk("m_wea", wea, (dp_kind == K_WR) ? dp_mask : 4'b0);
            chk("m_hrdata", HRDATA, (dp_kind == K_RD) ? ref_mem[dp_word] : 32'h0);
            chk("m_addrb", addrb, HADDR[AW+1:2]);
            if (dp_kind == K_WR) begin
                chk("m_addra", addra, dp_word);
                chk("m_dina", dina, HWDATA);
            end
        end
    end

    // One bus cycle: v=1 issues a NONSEQ transfer, wd is HWDATA for the previous transfer.
    task automatic ap(input bit v, input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd);
        @(posedge clka);
        #1;
        HSEL   = v;
        HTRANS = v ? 2'b10 : 2'b00;
        HWRITE = w;
        HADDR  = a;
        HSIZE  = sz;
        HWDATA = wd;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_wea", wea, 4'b0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 32'h0);

        ap(0, 0, 0, 0, 0);
        rst = 1'b0;

        // Word write then read, not adjacent.
        ap(1, 1, 32'h100, 2, 0);
        ap(0, 0, 0, 0, 32'hDEADBEEF);
        @(negedge clka);
        chk("w_wea", wea, 4'b1111);
        chk("w_addra", addra, 14'h40);
        chk("w_dina", dina, 32'hDEADBEEF);
        ap(0, 0, 0, 0, 0);
        ap(1, 0, 32'h100, 2, 0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("r_hrdata", HRDATA, 32'hDEADBEEF);
        chk("r_hreadyout", HREADYOUT, 1'b1);

        // Byte and halfword lanes over a preloaded word.
        ap(1, 1, 32'h0, 2, 0);
        ap(1, 1, 32'h3, 0, 32'h11223344);
        ap(0, 0, 0, 0, 32'hAA000000);
        @(negedge clka);
        chk("b_wea", wea, 4'b1000);
        ap(1, 0, 32'h0, 2, 0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("b_hrdata", HRDATA, 32'hAA223344);
        ap(1, 1, 32'h0, 1, 0);
        ap(0, 0, 0, 0, 32'h00005566);
        @(negedge clka);
        chk("h_wea", wea, 4'b0011);
        ap(1, 0, 32'h0, 2, 0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("h_hrdata", HRDATA, 32'hAA225566);

        // Write->read hazard on the same word, then on a different word.
        ap(1, 1, 32'h8, 2, 0);
        ap(1, 1, 32'hC, 2, 32'h0);
        ap(0, 0, 0, 0, 32'h12345678);
        ap(1, 1, 32'h9, 0, 0);
        ap(1, 0, 32'h8, 2, 32'h00007700);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("fwd_hrdata", HRDATA, 32'h00007700);
        chk("fwd_hreadyout", HREADYOUT, 1'b1);
        ap(1, 1, 32'h9, 0, 0);
        ap(1, 0, 32'hC, 2, 32'h00009900);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("nofwd_hrdata", HRDATA, 32'h12345678);

        // Misaligned word read: two-cycle ERROR.
        ap(1, 0, 32'h2, 2, 0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("e1_hreadyout", HREADYOUT, 1'b0);
        chk("e1_hresp", HRESP, 1'b1);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("e2_hreadyout", HREADYOUT, 1'b1);
        chk("e2_hresp", HRESP, 1'b1);

        // Oversized write: ERROR, no RAM write; a read issued in ERR2 proceeds.
        ap(1, 1, 32'h0, 3, 0);
        ap(0, 0, 0, 0, 32'hFFFFFFFF);
        @(negedge clka);
        chk("s3_e1_hreadyout", HREADYOUT, 1'b0);
        chk("s3_e1_hresp", HRESP, 1'b1);
        chk("s3_e1_wea", wea, 4'b0);
        ap(1, 0, 32'h0, 2, 32'hFFFFFFFF);
        @(negedge clka);
        chk("s3_e2_hresp", HRESP, 1'b1);
        chk("s3_e2_wea", wea, 4'b0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("s3_read_hrdata", HRDATA, 32'hAA225566);
        chk("s3_read_hresp", HRESP, 1'b0);

        // Reset during a write data phase.
        ap(1, 1, 32'h100, 2, 0);
        ap(0, 0, 0, 0, 32'hCAFEF00D);
        rst = 1'b1;
        ap(0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clka);
        chk("rw_wea", wea, 4'b0);
        chk("rw_hreadyout", HREADYOUT, 1'b1);
        chk("rw_hresp", HRESP, 1'b0);
        ap(1, 0, 32'h100, 2, 0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        chk("rw_hrdata", HRDATA, 32'hDEADBEEF);

        // Randomized transfers over a few words, with aliasing, stalls and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [15:0] upper;
            logic [1:0]  low;
            logic [2:0]  sz;
            upper = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom());
            low   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom());
            sz    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a     = {upper, 14'($urandom_range(0, 7)), low};
            @(posedge clka);
            #1;
            HSEL   = ($urandom_range(0, 7) != 0);
            HTRANS = 2'($urandom_range(0, 3));
            HWRITE = 1'($urandom());
            HADDR  = a;
            HSIZE  = sz;
            HWDATA = $urandom();
            stall  = ($urandom_range(0, 15) == 0);
            rst    = ($urandom_range(0, 299) == 0);
        end

        ap(0, 0, 0, 0, 0);
        stall = 1'b0;
        rst   = 1'b0;
        ap(0, 0, 0, 0, 0);
        ap(0, 0, 0, 0, 0);
        @(negedge clka);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
